qoi_dma_ctrl: RTL and testbench

//  Bus-mastering DMA sequencer for the QOI accelerator. Sits between the 65C02

---
 rtl/qoi_dma_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_qoi_dma_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qoi_dma_ctrl.sv
// DMA sequencer for the QOI accelerator: the CPU programs SRC/DST/LEN and starts a job;
// the block then stalls the CPU, streams pixel bytes to the encoder and writes encoded bytes back.
module qoi_dma_ctrl #(
  parameter int unsigned   AW      = 16,
  parameter logic [AW-1:0] DST_END = 16'hA000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [2:0]    addr,
  input  logic          we,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          cpu_rdy,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic [7:0]    bus_do,
  input  logic [7:0]    bus_di,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic          pix_last,
  input  logic          pix_ready,
  input  logic          enc_valid,
  input  logic [7:0]    enc_data,
  input  logic          enc_last,
  output logic          enc_ready,
  output logic          irq
);

  localparam int unsigned   LW       = 16;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] DST_LAST = DST_END - ADDR_ONE;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_PUSH, S_WAIT_ENC, S_WR, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] src, dst;
  logic [LW-1:0] len;
  logic [7:0]    pix_byte;
  logic          done, ovf, abrt, ie, discard;
  logic          ovf_set, discard_set, done_set;
  logic [7:0]    rd_mux;

  logic busy, reg_wr, reg_rd, ctrl_wr, start_cmd, abort_cmd;

  assign busy      = (state != S_IDLE);
  assign reg_wr    = cs && we;
  assign reg_rd    = cs && !we;
  assign ctrl_wr   = reg_wr && (addr == 3'd6);
  // ABORT in the same write suppresses START; START while busy is dropped
  assign start_cmd = ctrl_wr && data_i[0] && !data_i[1] && !busy;
  assign abort_cmd = ctrl_wr && data_i[1] && busy;
  assign done_set  = (state == S_DONE) || (start_cmd && (len == '0)) || abort_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      pix_byte <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      abrt     <= 1'b0;
      ie       <= 1'b0;
      discard  <= 1'b0;
      data_o   <= '0;
    end else begin
      state <= state_nx;
      if (reg_wr && !busy) begin
        case (addr)
          3'd0:    src[7:0]  <= data_i;
          3'd1:    src[15:8] <= data_i;
          3'd2:    dst[7:0]  <= data_i;
          3'd3:    dst[15:8] <= data_i;
          3'd4:    len[7:0]  <= data_i;
          3'd5:    len[15:8] <= data_i;
          default: ;
        endcase
      end
      if (state == S_PUSH && pix_ready) begin
        src <= src + ADDR_ONE;
        len <= len - LW'(1);
      end
      if (state == S_RD_DATA) pix_byte <= bus_di;
      if (state == S_WR) dst <= dst + ADDR_ONE;
      if (ctrl_wr) ie <= data_i[2];
      if (reg_rd) data_o <= rd_mux;
      // status read clears sticky flags; a same-cycle set still wins
      if (reg_rd && addr == 3'd6) begin
        done <= 1'b0;
        ovf  <= 1'b0;
        abrt <= 1'b0;
      end
      if (done_set)  done <= 1'b1;
      if (ovf_set)   ovf  <= 1'b1;
      if (abort_cmd) abrt <= 1'b1;
      if (discard_set) discard <= 1'b1;
      else if (abort_cmd || (discard && enc_valid && enc_last)) discard <= 1'b0;
    end
  end

  // Next state; every pass through WAIT_ENC lets pending encoder output drain before the next read
  always_comb begin
    state_nx    = state;
    ovf_set     = 1'b0;
    discard_set = 1'b0;
    case (state)
      S_IDLE:    if (start_cmd && len != '0) state_nx = S_RD_ADDR;
      S_RD_ADDR: state_nx = S_RD_DATA;
      S_RD_DATA: state_nx = S_PUSH;
      S_PUSH:    if (pix_ready) state_nx = S_WAIT_ENC;
      S_WAIT_ENC: begin
        if (enc_valid) begin
          if (dst >= DST_END) begin
            ovf_set     = 1'b1;
            discard_set = 1'b1;
            state_nx    = S_DONE;
          end else begin
            state_nx = S_WR;
          end
        end else if (len != '0) begin
          state_nx = S_RD_ADDR;
        end
      end
      S_WR: begin
        if (enc_last) begin
          state_nx = S_DONE;
        end else if (dst == DST_LAST) begin
          ovf_set     = 1'b1;
          discard_set = 1'b1;
          state_nx    = S_DONE;
        end else begin
          state_nx = S_WAIT_ENC;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_cmd) state_nx = S_IDLE;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      3'd0:    rd_mux = src[7:0];
      3'd1:    rd_mux = src[15:8];
      3'd2:    rd_mux = dst[7:0];
      3'd3:    rd_mux = dst[15:8];
      3'd4:    rd_mux = len[7:0];
      3'd5:    rd_mux = len[15:8];
      3'd6:    rd_mux = {3'b000, ie, abrt, ovf, done, busy};
      default: rd_mux = 8'h00;
    endcase
  end

  // Bus and stream strobes decode the state directly so reset releases them in the same cycle
  always_comb begin
    cpu_rdy   = rst || (state == S_IDLE);
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_do    = 8'h00;
    pix_valid = 1'b0;
    pix_data  = pix_byte;
    pix_last  = 1'b0;
    enc_ready = 1'b0;
    irq       = !rst && done && ie;
    if (!rst) begin
      case (state)
        S_RD_ADDR: bus_addr = src;
        S_WR: begin
          bus_addr = dst;
          bus_we   = 1'b1;
          bus_do   = enc_data;
        end
        S_PUSH: begin
          pix_valid = 1'b1;
          pix_last  = (len == LW'(1));
        end
        default: ;
      endcase
      enc_ready = (state == S_WR) || discard;
    end
  end

endmodule

// File: tb/tb_qoi_dma_ctrl.sv
// Scoreboard bench for qoi_dma_ctrl: memory and encoder models, expected bus writes and
// register reads queued at stimulus time and compared by a monitor when the DUT presents them.
module tb_qoi_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst, cs, we, pix_ready;
  logic [2:0]  addr;
  logic [7:0]  data_i, data_o, bus_do, pix_data, enc_data;
  logic [7:0]  bus_di = 8'h00;
  logic [15:0] bus_addr;
  logic        cpu_rdy, bus_we, pix_valid, pix_last, enc_ready, irq;
  logic        enc_valid = 1'b0, enc_last = 1'b0;

  always #5 clk = ~clk;

  qoi_dma_ctrl dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .we(we), .data_i(data_i), .data_o(data_o),
    .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_we(bus_we), .bus_do(bus_do), .bus_di(bus_di),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_last(enc_last), .enc_ready(enc_ready),
    .irq(irq)
  );

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [7:0] d; logic l; } enc_t;

  logic [7:0] rom [0:65535];
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  string      rd_nm[$];
  enc_t       enc_q[$];
  int         enc_mode = 0;
  int         pix_cnt = 0;
  int         checks = 0, passes = 0;
  int         wr_count = 0, watch_wc = 0;
  logic       watch_seen = 1'b0;
  logic [15:0] watch_addr = 16'hFFFF;
  logic       rd_vld = 1'b0;

  // Memory: read data one cycle after address; writes are checked, not stored
  always @(posedge clk) bus_di <= rom[bus_addr];

  always @(posedge clk) rd_vld <= cs && !we && !rst;

  // Encoder: emits bytes derived from each accepted pixel, per enc_mode
  always @(posedge clk) begin
    if (rst) begin
      enc_q.delete();
    end else begin
      if (enc_valid && enc_ready && enc_q.size() > 0) void'(enc_q.pop_front());
      if (pix_valid && pix_ready) begin
        pix_cnt++;
        case (enc_mode)
          0: enc_q.push_back({pix_data, pix_last});
          1: begin
            enc_q.push_back({pix_data, 1'b0});
            enc_q.push_back({~pix_data, pix_last});
          end
          2: for (int j = 0; j < 4; j++)
               enc_q.push_back({8'(pix_data + 8'(j)), pix_last && (j == 3)});
          default: ;
        endcase
      end
    end
    if (enc_q.size() > 0) begin
      enc_valid <= 1'b1;
      enc_data  <= enc_q[0].d;
      enc_last  <= enc_q[0].l;
    end else begin
      enc_valid <= 1'b0;
      enc_data  <= 8'h00;
      enc_last  <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus_we) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL bus_wr: unexpected write addr %h data %h", bus_addr, bus_do);
        end else begin
          e = exp_wr.pop_front();
          chk("bus_wr", {8'h00, bus_addr, bus_do}, {8'h00, e.a, e.d});
        end
      end
      if (!cpu_rdy && !bus_we && bus_addr == watch_addr && !watch_seen) begin
        watch_seen = 1'b1;
        watch_wc   = wr_count;
      end
      if (rd_vld) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL reg_rd: unexpected read data %h", data_o);
        end else begin
          chk(rd_nm.pop_front(), {24'h0, data_o}, {24'h0, exp_rd.pop_front()});
        end
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1 cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(posedge clk); #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    exp_rd.push_back(e);
    rd_nm.push_back(nm);
    @(posedge clk); #1 cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1 cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    wr(3'd0, s[7:0]); wr(3'd1, s[15:8]);
    wr(3'd2, d[7:0]); wr(3'd3, d[15:8]);
    wr(3'd4, l[7:0]); wr(3'd5, l[15:8]);
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (cpu_rdy !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, {31'h0, cpu_rdy}, 32'h1);
  endtask

  initial begin
    int   n, base, wc_base;
    logic seen_low;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[16'h8000] = 8'h11; rom[16'h8001] = 8'h22; rom[16'h8002] = 8'h33;
    rom[16'h8010] = 8'hAA; rom[16'h8011] = 8'hBB;
    rom[16'h8020] = 8'h40;
    rom[16'h8200] = 8'h5A;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; data_i = 8'h00; pix_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
    chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    chk("rst_enc_ready", {31'h0, enc_ready}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_data_o", {24'h0, data_o}, 32'h0);

    // zero-length job
    wr(3'd6, 8'h01);
    seen_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_low = seen_low | !cpu_rdy;
    end
    chk("len0_stall", {31'h0, seen_low}, 32'h0);
    rd(3'd6, 8'h02, "len0_status");

    // three-byte echo job with interrupt
    enc_mode = 0;
    setup(16'h8000, 16'h9000, 16'd3);
    exp_wr.push_back({16'h9000, 8'h11});
    exp_wr.push_back({16'h9001, 8'h22});
    exp_wr.push_back({16'h9002, 8'h33});
    wr(3'd6, 8'h05);
    chk("t1_busy", {31'h0, cpu_rdy}, 32'h0);
    wait_rdy("t1_done_rdy");
    chk("t1_irq", {31'h0, irq}, 32'h1);
    rd(3'd2, 8'h03, "t1_dst_lo");
    rd(3'd3, 8'h90, "t1_dst_hi");
    rd(3'd0, 8'h03, "t1_src_lo");
    rd(3'd4, 8'h00, "t1_len_lo");
    rd(3'd6, 8'h12, "t1_status");
    chk("t1_irq_clr", {31'h0, irq}, 32'h0);
    rd(3'd7, 8'h00, "t1_reg7");

    // two output bytes per pixel, stalled pixel acceptance
    enc_mode = 1;
    pix_ready = 1'b0;
    watch_addr = 16'h8011;
    wc_base = wr_count;
    setup(16'h8010, 16'h9100, 16'd2);
    exp_wr.push_back({16'h9100, 8'hAA});
    exp_wr.push_back({16'h9101, 8'h55});
    exp_wr.push_back({16'h9102, 8'hBB});
    exp_wr.push_back({16'h9103, 8'h44});
    wr(3'd6, 8'h01);
    n = 0;
    while (!pix_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("t3_pix_hold", {31'h0, pix_valid}, 32'h1);
      @(posedge clk); #1;
    end
    rd(3'd0, 8'h10, "t3_src_stalled");
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_rdy("t3_done_rdy");
    chk("t3_rd2_seen", {31'h0, watch_seen}, 32'h1);
    chk("t3_wr_before_rd2", 32'(watch_wc - wc_base), 32'd2);
    rd(3'd0, 8'h12, "t3_src_lo");
    rd(3'd6, 8'h02, "t3_status");

    // output window overflow
    enc_mode = 2;
    setup(16'h8020, 16'h9FFE, 16'd1);
    exp_wr.push_back({16'h9FFE, 8'h40});
    exp_wr.push_back({16'h9FFF, 8'h41});
    wr(3'd6, 8'h01);
    wait_rdy("t4_done_rdy");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_drained", 32'(enc_q.size()), 32'd0);
    chk("t4_enc_ready_off", {31'h0, enc_ready}, 32'h0);
    rd(3'd6, 8'h06, "t4_status");
    rd(3'd3, 8'hA0, "t4_dst_hi");
    rd(3'd2, 8'h00, "t4_dst_lo");

    // abort after ten pixels; writes and START while busy are ignored
    enc_mode = 3;
    setup(16'h8100, 16'h9200, 16'd100);
    base = pix_cnt;
    wr(3'd6, 8'h01);
    n = 0;
    while (pix_cnt - base < 10 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    pix_ready = 1'b0;
    chk("t5_pix10", 32'(pix_cnt - base), 32'd10);
    wr(3'd4, 8'h05);
    wr(3'd6, 8'h01);
    chk("t5_still_busy", {31'h0, cpu_rdy}, 32'h0);
    wr(3'd6, 8'h02);
    chk("t5_abort_rdy", {31'h0, cpu_rdy}, 32'h1);
    chk("t5_abort_pix", {31'h0, pix_valid}, 32'h0);
    rd(3'd6, 8'h0A, "t5_status");
    rd(3'd6, 8'h00, "t5_status_clr");
    rd(3'd0, 8'h0A, "t5_src_lo");
    rd(3'd1, 8'h81, "t5_src_hi");
    rd(3'd4, 8'h5A, "t5_len_lo");
    pix_ready = 1'b1;

    // reset in the middle of a write
    enc_mode = 0;
    setup(16'h8200, 16'h9300, 16'd3);
    wr(3'd6, 8'h01);
    n = 0;
    while (!bus_we && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_in_wr", {31'h0, bus_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", {31'h0, bus_we}, 32'h0);
    chk("t6_rst_rdy", {31'h0, cpu_rdy}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    rd(3'd0, 8'h00, "t6_src_lo");
    rd(3'd3, 8'h00, "t6_dst_hi");
    rd(3'd4, 8'h00, "t6_len_lo");
    rd(3'd6, 8'h00, "t6_status");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
